// File: rtl/audio_pkg.sv
// Shared audio-path types and I2S word-select encoding for the pedal-board output stages.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: toggles BCLK every BCLK_HALF cycles and flags the edge that toggles it.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_HALF = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic bclk_o,
  output logic fall_evt_c_o,
  output logic rise_evt_c_o
);

  localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc_c;

  always_comb begin
    tc_c      = (div_cnt_q == DIV_W'(BCLK_HALF - 1));
    div_cnt_d = tc_c ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = tc_c ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // Strobes are high in the cycle whose closing edge toggles BCLK.
  assign bclk_o       = bclk_q;
  assign fall_evt_c_o = tc_c & bclk_q;
  assign rise_evt_c_o = tc_c & ~bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter to the codec DAC: one-frame hold buffer, frame repeat on underrun.
module i2s_dac_tx #(
  parameter int unsigned SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int unsigned SLOT_W    = 32,
  parameter int unsigned BCLK_HALF = 8,
  parameter int unsigned UCNT_W    = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [SAMPLE_W-1:0] Sample_l,
  input  logic [SAMPLE_W-1:0] Sample_r,
  input  logic                Sample_valid,
  output logic                Sample_ready,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDATA,
  output logic                Frame_start,
  output logic                Underrun,
  output logic [UCNT_W-1:0]   Underrun_cnt
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  logic                fall_evt_c;
  logic                rise_evt_unused;

  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                start_pend_q, start_pend_d;
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;

  logic                accept_c;
  logic [BIT_W-1:0]    bit_nxt_c, slot_b_c;
  logic                right_c;
  logic [SAMPLE_W-1:0] word_c, word_sh_c;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk_i        (CLK),
    .rst_n_i      (RESET_N),
    .bclk_o       (BCLK),
    .fall_evt_c_o (fall_evt_c),
    .rise_evt_c_o (rise_evt_unused)
  );

  assign accept_c = Sample_valid & ~hold_full_q;

  always_comb begin
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    frame_l_d     = frame_l_q;
    frame_r_d     = frame_r_q;
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    start_pend_d  = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    ucnt_d        = ucnt_q;

    // Position of the bit that the coming fall event launches.
    bit_nxt_c = (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
    right_c   = (bit_nxt_c >= BIT_W'(SLOT_W));
    slot_b_c  = right_c ? bit_nxt_c - BIT_W'(SLOT_W) : bit_nxt_c;
    word_c    = right_c ? frame_r_q : frame_l_q;
    word_sh_c = word_c << (slot_b_c - BIT_W'(1));

    if (fall_evt_c) begin
      bit_cnt_d    = bit_nxt_c;
      lrclk_d      = right_c ? audio_pkg::I2S_RIGHT : audio_pkg::I2S_LEFT;
      sdata_d      = ((slot_b_c != '0) && (slot_b_c <= BIT_W'(SAMPLE_W))) ?
                     word_sh_c[SAMPLE_W-1] : 1'b0;
      start_pend_d = (bit_nxt_c == '0);
    end

    if (accept_c) begin
      hold_l_d    = Sample_l;
      hold_r_d    = Sample_r;
      hold_full_d = 1'b1;
    end

    // Frame start: take the held frame, or keep repeating the old one and count the gap.
    if (start_pend_q) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
        if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      frame_l_q     <= '0;
      frame_r_q     <= '0;
      bit_cnt_q     <= BIT_W'(FRAME_BITS - 1);
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      start_pend_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucnt_q        <= '0;
    end else begin
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      frame_l_q     <= frame_l_d;
      frame_r_q     <= frame_r_d;
      bit_cnt_q     <= bit_cnt_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      start_pend_q  <= start_pend_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      ucnt_q        <= ucnt_d;
    end
  end

  assign Sample_ready = ~hold_full_q;
  assign LRCLK        = lrclk_q;
  assign SDATA        = sdata_q;
  assign Frame_start  = frame_start_q;
  assign Underrun     = underrun_q;
  assign Underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: startup timing, serialisation, backpressure, underrun, reset.
module tb_i2s_dac_tx;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] Sample_l, Sample_r;
  logic        Sample_valid;
  logic        Sample_ready, BCLK, LRCLK, SDATA, Frame_start, Underrun;
  logic [7:0]  Underrun_cnt;

  // Fast-frame instance used only for counter saturation.
  logic        s_rst_n;
  logic [15:0] s_zero = 16'h0000;
  logic        s_valid = 1'b0;
  logic        s_ready_unused, s_bclk_unused, s_lrclk_unused, s_sdata_unused;
  logic        s_fs, s_ur;
  logic [7:0]  s_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int acc_cnt = 0;

  logic [15:0] bp_l [4];
  logic [15:0] bp_r [4];
  logic [15:0] cap_l [4];
  logic [15:0] cap_r [4];
  logic        cap_ur [4];
  logic        cap_rdy [4];
  bit          cap_ok [4];
  bit          snd_ok [4];

  always #5 CLK = ~CLK;

  i2s_dac_tx u_dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .Sample_l     (Sample_l),
    .Sample_r     (Sample_r),
    .Sample_valid (Sample_valid),
    .Sample_ready (Sample_ready),
    .BCLK         (BCLK),
    .LRCLK        (LRCLK),
    .SDATA        (SDATA),
    .Frame_start  (Frame_start),
    .Underrun     (Underrun),
    .Underrun_cnt (Underrun_cnt)
  );

  i2s_dac_tx #(
    .SAMPLE_W  (16),
    .SLOT_W    (17),
    .BCLK_HALF (1),
    .UCNT_W    (8)
  ) u_sat (
    .CLK          (CLK),
    .RESET_N      (s_rst_n),
    .Sample_l     (s_zero),
    .Sample_r     (s_zero),
    .Sample_valid (s_valid),
    .Sample_ready (s_ready_unused),
    .BCLK         (s_bclk_unused),
    .LRCLK        (s_lrclk_unused),
    .SDATA        (s_sdata_unused),
    .Frame_start  (s_fs),
    .Underrun     (s_ur),
    .Underrun_cnt (s_cnt)
  );

  always @(posedge CLK)
    if (RESET_N && Sample_valid && Sample_ready) acc_cnt <= acc_cnt + 1;

  task automatic apply_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    Sample_valid = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic next_rise(output bit ok);
    logic prev;
    prev = BCLK;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (BCLK && !prev) begin ok = 1'b1; break; end
      prev = BCLK;
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (Frame_start) begin ok = 1'b1; break; end
    end
  endtask

  // Must be called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] l, input logic [15:0] r, output bit ok);
    Sample_l = l;
    Sample_r = r;
    Sample_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (Sample_ready) begin @(negedge CLK); ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  // Receives one frame as a codec would, sampling SDATA/LRCLK on BCLK rising edges.
  task automatic capture_frame(output bit ok, output logic [15:0] l, output logic [15:0] r,
                               output logic pad, output logic lr_ok, output logic ur,
                               output logic rdy_mid);
    bit got;
    wait_fs(got);
    ok = got;
    ur = Underrun;
    rdy_mid = Sample_ready;
    pad = 1'b0;
    lr_ok = 1'b1;
    l = '0;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      next_rise(got);
      ok = ok & got;
      if (i >= 1 && i <= 16) l[16-i] = SDATA;
      else if (i >= 33 && i <= 48) r[48-i] = SDATA;
      else pad = pad | SDATA;
      if (LRCLK !== (i >= 32)) lr_ok = 1'b0;
      if (i == 32) rdy_mid = Sample_ready;
    end
  endtask

  // Must be called at the negedge where RESET_N has just been released with the hold empty.
  task automatic check_startup(input string tag);
    int   rise_at, fall_at, fs_at;
    logic ur_at, prev;
    rise_at = -1; fall_at = -1; fs_at = -1; ur_at = 1'b0;
    prev = BCLK;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (rise_at < 0 && BCLK && !prev) rise_at = n;
      if (fall_at < 0 && rise_at >= 0 && !BCLK && prev) fall_at = n;
      if (fs_at < 0 && Frame_start) begin fs_at = n; ur_at = Underrun; end
      prev = BCLK;
    end
    n_cmp++; if (rise_at !== 8) begin n_fail++; $display("FAIL %s_bclk_rise: got %0d want 8", tag, rise_at); end
    n_cmp++; if (fall_at !== 16) begin n_fail++; $display("FAIL %s_bclk_fall: got %0d want 16", tag, fall_at); end
    n_cmp++; if (fs_at !== 17) begin n_fail++; $display("FAIL %s_frame_start: got %0d want 17", tag, fs_at); end
    n_cmp++; if (ur_at !== 1'b1) begin n_fail++; $display("FAIL %s_first_underrun: got %b want 1", tag, ur_at); end
    n_cmp++; if (Underrun_cnt !== 8'd1) begin n_fail++; $display("FAIL %s_ucnt: got %0d want 1", tag, Underrun_cnt); end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    Sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++; if ({BCLK, LRCLK, SDATA} !== 3'b000) begin n_fail++; $display("FAIL t1_io_in_reset: got %b want 000", {BCLK, LRCLK, SDATA}); end
    end
    n_cmp++; if (Sample_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready: got %b want 1", Sample_ready); end
    n_cmp++; if ({Frame_start, Underrun} !== 2'b00) begin n_fail++; $display("FAIL t1_pulses: got %b want 00", {Frame_start, Underrun}); end
    n_cmp++; if (Underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL t1_ucnt: got %0d want 0", Underrun_cnt); end
    RESET_N = 1'b1;
    check_startup("t1");
  endtask

  task automatic test_serialise();
    bit ok, sok;
    logic [15:0] l, r;
    logic pad, lr_ok, ur, rdy;
    apply_reset();
    send(16'h3FB1, 16'hC04E, sok);
    Sample_valid = 1'b0;
    capture_frame(ok, l, r, pad, lr_ok, ur, rdy);
    n_cmp++; if ({sok, ok} !== 2'b11) begin n_fail++; $display("FAIL t2_handshake_timeout: got %b want 11", {sok, ok}); end
    n_cmp++; if (l !== 16'h3FB1) begin n_fail++; $display("FAIL t2_left: got %h want 3fb1", l); end
    n_cmp++; if (r !== 16'hC04E) begin n_fail++; $display("FAIL t2_right: got %h want c04e", r); end
    n_cmp++; if (pad !== 1'b0) begin n_fail++; $display("FAIL t2_pad_bits: got %b want 0", pad); end
    n_cmp++; if (lr_ok !== 1'b1) begin n_fail++; $display("FAIL t2_lrclk: got %b want 1", lr_ok); end
    n_cmp++; if ({ur, Underrun_cnt} !== 9'd0) begin n_fail++; $display("FAIL t2_no_underrun: got %h want 000", {ur, Underrun_cnt}); end
  endtask

  task automatic test_back_to_back();
    int acc0;
    bp_l[0] = 16'h1111; bp_r[0] = 16'h8888;
    bp_l[1] = 16'h2222; bp_r[1] = 16'h9999;
    bp_l[2] = 16'hFFFF; bp_r[2] = 16'h0001;
    bp_l[3] = 16'h8000; bp_r[3] = 16'h7FFF;
    apply_reset();
    acc0 = acc_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) send(bp_l[k], bp_r[k], snd_ok[k]);
        Sample_valid = 1'b0;
      end
      begin
        logic pad, lr_ok;
        for (int k = 0; k < 4; k++)
          capture_frame(cap_ok[k], cap_l[k], cap_r[k], pad, lr_ok, cap_ur[k], cap_rdy[k]);
      end
    join
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({snd_ok[k], cap_ok[k]} !== 2'b11) begin n_fail++; $display("FAIL t3_timeout[%0d]: got %b want 11", k, {snd_ok[k], cap_ok[k]}); end
      n_cmp++; if ({cap_l[k], cap_r[k]} !== {bp_l[k], bp_r[k]}) begin n_fail++; $display("FAIL t3_order[%0d]: got %h want %h", k, {cap_l[k], cap_r[k]}, {bp_l[k], bp_r[k]}); end
      n_cmp++; if (cap_ur[k] !== 1'b0) begin n_fail++; $display("FAIL t3_underrun[%0d]: got %b want 0", k, cap_ur[k]); end
      n_cmp++; if (cap_rdy[k] !== (k == 3)) begin n_fail++; $display("FAIL t3_ready_mid[%0d]: got %b want %b", k, cap_rdy[k], (k == 3)); end
    end
    n_cmp++; if (acc_cnt - acc0 !== 4) begin n_fail++; $display("FAIL t3_accepts: got %0d want 4", acc_cnt - acc0); end
    n_cmp++; if (Underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL t3_ucnt: got %0d want 0", Underrun_cnt); end
  endtask

  task automatic test_underrun();
    bit ok, sok;
    logic [15:0] l, r;
    logic pad, lr_ok, ur, rdy;
    int urs;
    apply_reset();
    send(16'h8001, 16'h7FFE, sok);
    Sample_valid = 1'b0;
    urs = 0;
    for (int k = 0; k < 4; k++) begin
      capture_frame(ok, l, r, pad, lr_ok, ur, rdy);
      n_cmp++; if ({sok, ok} !== 2'b11) begin n_fail++; $display("FAIL t4_timeout[%0d]: got %b want 11", k, {sok, ok}); end
      n_cmp++; if ({l, r, pad} !== {16'h8001, 16'h7FFE, 1'b0}) begin n_fail++; $display("FAIL t4_repeat[%0d]: got %h want %h", k, {l, r, pad}, {16'h8001, 16'h7FFE, 1'b0}); end
      n_cmp++; if (ur !== (k != 0)) begin n_fail++; $display("FAIL t4_underrun[%0d]: got %b want %b", k, ur, (k != 0)); end
      if (ur === 1'b1) urs++;
    end
    n_cmp++; if (urs !== 3) begin n_fail++; $display("FAIL t4_pulses: got %0d want 3", urs); end
    n_cmp++; if (Underrun_cnt !== 8'd3) begin n_fail++; $display("FAIL t4_ucnt: got %0d want 3", Underrun_cnt); end
  endtask

  task automatic test_saturation();
    int n;
    @(negedge CLK);
    s_rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    s_rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 25000; c++) begin
      @(negedge CLK);
      if (s_fs) begin
        n++;
        if (n == 1) begin
          n_cmp++; if ({s_ur, s_cnt} !== 9'h101) begin n_fail++; $display("FAIL t5_first: got %h want 101", {s_ur, s_cnt}); end
        end
        if (n == 254) begin
          n_cmp++; if (s_cnt !== 8'hFE) begin n_fail++; $display("FAIL t5_cnt_254: got %h want fe", s_cnt); end
        end
        if (n == 255) begin
          n_cmp++; if (s_cnt !== 8'hFF) begin n_fail++; $display("FAIL t5_cnt_255: got %h want ff", s_cnt); end
        end
        if (n == 300) begin
          n_cmp++; if ({s_ur, s_cnt} !== 9'h1FF) begin n_fail++; $display("FAIL t5_cnt_300: got %h want 1ff", {s_ur, s_cnt}); end
          break;
        end
      end
    end
    n_cmp++; if (n !== 300) begin n_fail++; $display("FAIL t5_frames: got %0d want 300", n); end
  endtask

  task automatic test_reset_midframe();
    bit ok1, ok2, ok3, ok4, okr;
    apply_reset();
    wait_fs(ok1);
    send(16'h1234, 16'h5678, ok2);
    wait_fs(ok3);
    send(16'hABCD, 16'hEF01, ok4);
    Sample_valid = 1'b0;
    okr = 1'b1;
    for (int i = 0; i <= 42; i++) begin
      bit g;
      next_rise(g);
      okr = okr & g;
    end
    n_cmp++; if ({ok1, ok2, ok3, ok4, okr} !== 5'b11111) begin n_fail++; $display("FAIL t6_timeout: got %b want 11111", {ok1, ok2, ok3, ok4, okr}); end
    n_cmp++; if ({LRCLK, Sample_ready, Underrun_cnt} !== {1'b1, 1'b0, 8'd1}) begin n_fail++; $display("FAIL t6_pre_reset: got %h want 201", {LRCLK, Sample_ready, Underrun_cnt}); end
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({BCLK, LRCLK, SDATA, Frame_start, Underrun} !== 5'b00000) begin n_fail++; $display("FAIL t6_io_in_reset: got %b want 00000", {BCLK, LRCLK, SDATA, Frame_start, Underrun}); end
    n_cmp++; if ({Sample_ready, Underrun_cnt} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL t6_hold_cnt_reset: got %h want 100", {Sample_ready, Underrun_cnt}); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    check_startup("t6");
  endtask

  initial begin
    RESET_N = 1'b0;
    s_rst_n = 1'b0;
    Sample_valid = 1'b0;
    Sample_l = '0;
    Sample_r = '0;
    test_reset();
    test_serialise();
    test_back_to_back();
    test_underrun();
    test_saturation();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
